neopixel_rx: RTL

Decodes a WS2812 ("NeoPixel") single-wire serial stream back into 24-bit pixel words, one per LED, in arrival order. It is the receiving end of the NEO_OUT waveform produced by the board's NeoPixel driver. The team uses it in two places: as a self-checking monitor in driver benches, and looped back on-chip so the driver's output can be verified in hardware. It runs from the 50 MHz system clock (20 ns/cycle), and all pulse widths are measured in clock cycles.

---
 rtl/neopixel_rx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/neopixel_rx.sv
// WS2812 single-wire receiver: measures high/low pulse widths on a
// synchronized line and rebuilds 24-bit GRB words, one per LED slot.
module neopixel_rx #(
  parameter int HIGH_THRESH  = 30,
  parameter int MIN_HIGH     = 8,
  parameter int MAX_HIGH     = 55,
  parameter int LATCH_CYCLES = 2500,
  parameter int NUM_PIXELS   = 32,
  localparam int IW = $clog2(NUM_PIXELS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          neo_in,
  output logic [23:0]   pixel_data,
  output logic          pixel_valid,
  output logic [IW-1:0] pixel_index,
  output logic          frame_done,
  output logic          bit_error,
  output logic          busy
);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [11:0]   HI_T  = 12'(HIGH_THRESH);
  localparam logic [11:0]   MIN_H = 12'(MIN_HIGH);
  localparam logic [11:0]   MAX_H = 12'(MAX_HIGH);
  localparam logic [11:0]   LATCH = 12'(LATCH_CYCLES);
  localparam logic [IW-1:0] LAST  = IW'(NUM_PIXELS - 1);

  state_t        state_q, state_d;
  logic          s1_q, s_q;
  logic [11:0]   cnt_q, cnt_d, cnt_inc;
  logic [4:0]    bitcnt_q, bitcnt_d;
  logic [23:0]   shreg_q, shreg_d, word;
  logic [IW-1:0] slot_q, slot_d;
  logic          full_q, full_d;
  logic [23:0]   data_q, data_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          bit_v;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    slot_d   = slot_q;
    full_d   = full_q;
    data_d   = data_q;
    idx_d    = idx_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    bit_v    = (cnt_q >= HI_T);
    word     = {shreg_q[22:0], bit_v};
    cnt_inc  = (cnt_q == 12'hfff) ? cnt_q : cnt_q + 12'd1;
    unique case (state_q)
      WAIT_IDLE: begin
        if (s_q) begin
          cnt_d = 12'd0;
        end else if (cnt_q == LATCH) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      IDLE: begin
        if (s_q) begin
          cnt_d   = 12'd1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if ((s_q && cnt_q >= MAX_H) || (!s_q && cnt_q < MIN_H)) begin
          err_d    = 1'b1;
          state_d  = WAIT_IDLE;
          cnt_d    = 12'd0;
          bitcnt_d = 5'd0;
          slot_d   = '0;
          full_d   = 1'b0;
        end else if (s_q) begin
          cnt_d = cnt_inc;
        end else begin
          shreg_d = word;
          cnt_d   = 12'd1;
          state_d = LOW;
          if (bitcnt_q == 5'd23) begin
            bitcnt_d = 5'd0;
            if (!full_q) begin
              data_d  = word;
              idx_d   = slot_q;
              valid_d = 1'b1;
              if (slot_q == LAST) full_d = 1'b1;
              else slot_d = slot_q + 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + 5'd1;
          end
        end
      end
      LOW: begin
        // Latch wins over a late rising edge once the low time is met.
        if (cnt_q == LATCH) begin
          done_d   = 1'b1;
          err_d    = (bitcnt_q != 5'd0);
          bitcnt_d = 5'd0;
          slot_d   = '0;
          full_d   = 1'b0;
          state_d  = IDLE;
        end else if (s_q) begin
          cnt_d   = 12'd1;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= WAIT_IDLE;
      s1_q     <= 1'b0;
      s_q      <= 1'b0;
      cnt_q    <= 12'd0;
      bitcnt_q <= 5'd0;
      shreg_q  <= 24'd0;
      slot_q   <= '0;
      full_q   <= 1'b0;
      data_q   <= 24'd0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= neo_in;
      s_q      <= s1_q;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      slot_q   <= slot_d;
      full_q   <= full_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign pixel_data  = data_q;
  assign pixel_valid = valid_q;
  assign pixel_index = idx_q;
  assign frame_done  = done_q;
  assign bit_error   = err_q;
  assign busy        = (state_q != IDLE);

endmodule
